// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: resolves load-use, multi-cycle divide,
// data-bus wait and taken-jump hazards by driving the holds and flushes of the
// PC and pipeline registers. Also keeps a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_regs_rs1,
  input  logic [4:0]       id_regs_rs2,
  input  logic [4:0]       ex_regs_rd,
  input  logic             ex_ctrl_mem_read,
  input  logic             ex_jump_flag,
  input  logic             ex_div_start,
  input  logic             div_done,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    StIdle,
    StLoadStall,
    StDivWait,
    StMemWait
  } state_e;

  // The first bubble is issued from IDLE, so LOAD_STALL covers the rest.
  localparam logic [2:0] BubReload = 3'(LOAD_BUBBLES - 1);
  localparam bit         MultiBubble = (LOAD_BUBBLES > 1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [2:0]       bub_q, bub_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_wait;
  logic hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
  logic flush_if_id, flush_id_ex;

  assign load_use = ex_ctrl_mem_read && (ex_regs_rd != 5'd0) &&
                    ((id_regs_rs1 == ex_regs_rd) || (id_regs_rs2 == ex_regs_rd));
  assign mem_wait = mem_req && !mem_ack;

  // Next-state and hold/flush decode; a bus wait overrides every other hazard.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    bub_d       = bub_q;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    hold_ex_mem = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;

    if (mem_wait) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      hold_id_ex  = 1'b1;
      hold_ex_mem = 1'b1;
      state_d     = StMemWait;
      bub_d       = 3'd0;
      // Only an outstanding divide survives a bus wait; an interrupted
      // load stall is already covered by the frozen pipeline.
      if (state_q == StDivWait) begin
        ret_d = StDivWait;
      end else if (state_q != StMemWait) begin
        ret_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ex_div_start) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            hold_id_ex  = 1'b1;
            hold_ex_mem = 1'b1;
            state_d     = StDivWait;
          end else if (ex_jump_flag) begin
            // A coincident load-use is moot: its consumer is flushed here.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (load_use) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
            if (MultiBubble) begin
              bub_d   = BubReload;
              state_d = StLoadStall;
            end
          end
        end
        StLoadStall: begin
          // EX carries a bubble here, so jumps and divides cannot originate.
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          bub_d       = bub_q - 3'd1;
          if (bub_q == 3'd1) begin
            state_d = StIdle;
          end
        end
        StDivWait: begin
          if (div_done) begin
            state_d = StIdle;
          end else begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            hold_id_ex  = 1'b1;
            hold_ex_mem = 1'b1;
          end
        end
        StMemWait: begin
          // Completion cycle: MEM result not yet written, keep holding.
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          hold_id_ex  = 1'b1;
          hold_ex_mem = 1'b1;
          state_d     = ret_q;
          ret_d       = StIdle;
        end
        default: begin
          state_d = StIdle;
          ret_d   = StIdle;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, return state, bubble counter and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      bub_q       <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      bub_q       <= bub_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_hold      = hold_pc;
  assign if_id_hold   = hold_if_id;
  assign id_ex_hold   = hold_id_ex;
  assign ex_mem_hold  = hold_ex_mem;
  assign if_id_flush  = flush_if_id;
  assign id_ex_flush  = flush_id_ex;
  assign stall_busy   = (state_q != StIdle);
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load bubbles, 32- and 4-bit
// counters) share stimulus and are compared each cycle against a model built
// from pending-work bookkeeping rather than an explicit state machine.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_regs_rs1, id_regs_rs2, ex_regs_rd;
  logic       ex_ctrl_mem_read, ex_jump_flag, ex_div_start, div_done, mem_req, mem_ack;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_busy;
  logic [31:0] a_sc;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_busy;
  logic [3:0]  b_sc;

  logic [6:0]  obs_v [2];
  logic [31:0] sc_obs[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(32)) u_dut_lb1 (
    .clk(clk), .rst_n(rst_n),
    .id_regs_rs1(id_regs_rs1), .id_regs_rs2(id_regs_rs2), .ex_regs_rd(ex_regs_rd),
    .ex_ctrl_mem_read(ex_ctrl_mem_read), .ex_jump_flag(ex_jump_flag),
    .ex_div_start(ex_div_start), .div_done(div_done),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(a_pc), .if_id_hold(a_ifid), .id_ex_hold(a_idex), .ex_mem_hold(a_exmem),
    .if_id_flush(a_fifid), .id_ex_flush(a_fidex), .stall_busy(a_busy), .stall_cycles(a_sc)
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(4)) u_dut_lb3 (
    .clk(clk), .rst_n(rst_n),
    .id_regs_rs1(id_regs_rs1), .id_regs_rs2(id_regs_rs2), .ex_regs_rd(ex_regs_rd),
    .ex_ctrl_mem_read(ex_ctrl_mem_read), .ex_jump_flag(ex_jump_flag),
    .ex_div_start(ex_div_start), .div_done(div_done),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(b_pc), .if_id_hold(b_ifid), .id_ex_hold(b_idex), .ex_mem_hold(b_exmem),
    .if_id_flush(b_fifid), .id_ex_flush(b_fidex), .stall_busy(b_busy), .stall_cycles(b_sc)
  );

  assign obs_v[0]  = {a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_busy};
  assign obs_v[1]  = {b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_busy};
  assign sc_obs[0] = a_sc;
  assign sc_obs[1] = {28'd0, b_sc};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending work per instance.
  int unsigned     lb_cfg [2] = '{1, 3};
  longint unsigned max_cfg[2] = '{64'hFFFF_FFFF, 64'd15};
  int              lb_left[2];   // load bubbles still owed after the current one
  bit              div_pend[2];  // divide outstanding
  bit              in_mem[2];    // a bus wait has frozen the pipeline
  longint unsigned stalls[2];
  int              n_lb_left[2];
  bit              n_div_pend[2];
  bit              n_in_mem[2];
  longint unsigned n_stalls[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lb_left[k] = 0; div_pend[k] = 1'b0; in_mem[k] = 1'b0; stalls[k] = 0;
    end
  endtask

  // Expected outputs {pc,if_id,id_ex,ex_mem hold, if_id,id_ex flush, busy}.
  task automatic model_eval(input int k, output logic [6:0] e);
    bit lu, mw, hp, hi, he, hm, fi, fe, busy;
    lu = ex_ctrl_mem_read && (ex_regs_rd != 0) &&
         (id_regs_rs1 == ex_regs_rd || id_regs_rs2 == ex_regs_rd);
    mw = mem_req && !mem_ack;
    {hp, hi, he, hm, fi, fe} = 6'b0;
    busy = in_mem[k] || div_pend[k] || (lb_left[k] > 0);
    n_lb_left[k] = lb_left[k]; n_div_pend[k] = div_pend[k]; n_in_mem[k] = in_mem[k];
    if (in_mem[k]) begin
      {hp, hi, he, hm} = 4'hF;
      n_in_mem[k] = mw;
    end else if (mw) begin
      {hp, hi, he, hm} = 4'hF;
      n_in_mem[k] = 1'b1;
      n_lb_left[k] = 0;
    end else if (div_pend[k]) begin
      if (div_done) n_div_pend[k] = 1'b0;
      else {hp, hi, he, hm} = 4'hF;
    end else if (lb_left[k] > 0) begin
      hp = 1; hi = 1; fe = 1;
      n_lb_left[k] = lb_left[k] - 1;
    end else if (ex_div_start) begin
      {hp, hi, he, hm} = 4'hF;
      n_div_pend[k] = 1'b1;
    end else if (ex_jump_flag) begin
      fi = 1; fe = 1;
    end else if (lu) begin
      hp = 1; hi = 1; fe = 1;
      n_lb_left[k] = int'(lb_cfg[k]) - 1;
    end
    n_stalls[k] = stalls[k] + ((hp && stalls[k] < max_cfg[k]) ? 64'd1 : 64'd0);
    e = {hp, hi, he, hm, fi, fe, busy};
  endtask

  task automatic drive_cycle(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic mr, input logic jf,
                             input logic ds, input logic dd, input logic rq,
                             input logic ak);
    logic [6:0] e;
    @(negedge clk);
    id_regs_rs1 = rs1; id_regs_rs2 = rs2; ex_regs_rd = rd;
    ex_ctrl_mem_read = mr; ex_jump_flag = jf; ex_div_start = ds; div_done = dd;
    mem_req = rq; mem_ack = ak;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, e);
      check_eq(k == 0 ? "lb1_ctl" : "lb3_ctl", {25'd0, obs_v[k]}, {25'd0, e});
      check_eq(k == 0 ? "lb1_stall_cycles" : "lb3_stall_cycles", sc_obs[k], 32'(stalls[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      lb_left[k] = n_lb_left[k]; div_pend[k] = n_div_pend[k];
      in_mem[k] = n_in_mem[k]; stalls[k] = n_stalls[k];
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; effect must be immediate.
  task automatic pulse_reset();
    @(negedge clk);
    {ex_ctrl_mem_read, ex_jump_flag, ex_div_start, div_done, mem_req, mem_ack} = 6'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
    check_eq("rst_lb1_stall_cycles", a_sc, 32'd0);
    check_eq("rst_lb3_stall_cycles", {28'd0, b_sc}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_regs_rs1 = 0; id_regs_rs2 = 0; ex_regs_rd = 0;
    {ex_ctrl_mem_read, ex_jump_flag, ex_div_start, div_done, mem_req, mem_ack} = 6'b0;
    model_reset();
    #12;
    check_eq("reset_outputs", {18'd0, obs_v[0], obs_v[1]}, 32'd0);
    check_eq("reset_stall_cycles", a_sc | {28'd0, b_sc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs2 for one cycle.
    drive_cycle(5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 0, 0);
    idle_cycles(4);
    // rd = x0 never stalls.
    drive_cycle(5'd0, 5'd7, 5'd0, 1, 0, 0, 0, 0, 0);
    idle_cycles(2);
    // Jump together with load-use: flush only.
    drive_cycle(5'd3, 5'd0, 5'd3, 1, 1, 0, 0, 0, 0);
    idle_cycles(2);
    // Divide with done six cycles after start.
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    idle_cycles(5);
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
    idle_cycles(2);
    // Bus wait inside a divide, then resume waiting for done.
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    idle_cycles(2);
    repeat (3) drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
    idle_cycles(2);
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
    idle_cycles(1);
    // Long divide drives the 4-bit counter into saturation.
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    idle_cycles(19);
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
    idle_cycles(1);
    // Reset in the middle of a divide; a later done is ignored.
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    idle_cycles(2);
    pulse_reset();
    drive_cycle(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
    idle_cycles(1);

    // Randomized traffic over a small register window to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rs1, rs2, rd;
      logic mr, jf, ds, dd, rq, ak;
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      mr  = ($urandom_range(0, 9) < 3);
      jf  = ($urandom_range(0, 99) < 15);
      ds  = ($urandom_range(0, 19) == 0);
      dd  = !ds && ($urandom_range(0, 19) < 3);
      rq  = ($urandom_range(0, 9) < 3);
      ak  = ($urandom_range(0, 1) == 1);
      drive_cycle(rs1, rs2, rd, mr, jf, ds, dd, rq, ak);
      if (i % 1000 == 999) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
